// File: rtl/button_conditioner_if.sv
// Button conditioner port bundle: raw button inputs in, conditioned levels and pulses out.
interface button_conditioner_if #(
   parameter int NUM_BTN = 5
);
   logic [NUM_BTN-1:0] btn_in;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_release;
   logic [NUM_BTN-1:0] btn_held;
   logic               any_press;

   modport master (
      output btn_in,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_held,
      input  any_press
   );

   modport slave (
      input  btn_in,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_held,
      output any_press
   );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel 2-FF sync, debounce, edge detect and hold/auto-repeat for raw push buttons.
// Every output is registered; channels are independent.
module button_conditioner #(
   parameter int NUM_BTN         = 5,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 20,
   parameter int REPEAT_CYCLES   = 8,
   parameter int REPEAT_EN       = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   button_conditioner_if.slave  bus
);
   localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);
   localparam logic          REP_ON    = (REPEAT_EN != 0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      REPEAT  = 2'd2
   } state_t;

   logic [NUM_BTN-1:0] sync1_r, sync2_r;
   logic [NUM_BTN-1:0] level_r, level_s;
   logic [NUM_BTN-1:0] rise_s, fall_s;
   logic [NUM_BTN-1:0] press_r, press_s;
   logic [NUM_BTN-1:0] release_r, release_s;
   logic [NUM_BTN-1:0] held_r, held_s;
   logic               any_press_r;
   logic [DW-1:0]      db_cnt_r [NUM_BTN];
   logic [DW-1:0]      db_cnt_s [NUM_BTN];
   logic [TW-1:0]      timer_r  [NUM_BTN];
   logic [TW-1:0]      timer_s  [NUM_BTN];
   state_t             state_r  [NUM_BTN];
   state_t             state_s  [NUM_BTN];

   // Debounce and hold/repeat next-state logic; the FSM sees the next level so press lines up with level.
   always_comb begin
      level_s   = level_r;
      rise_s    = '0;
      fall_s    = '0;
      press_s   = '0;
      release_s = '0;
      held_s    = held_r;
      db_cnt_s  = db_cnt_r;
      timer_s   = timer_r;
      state_s   = state_r;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (sync2_r[i] == level_r[i]) begin
            db_cnt_s[i] = '0;
         end else if (db_cnt_r[i] == DB_LAST) begin
            level_s[i]  = sync2_r[i];
            db_cnt_s[i] = '0;
         end else begin
            db_cnt_s[i] = db_cnt_r[i] + DW'(1);
         end
         rise_s[i] = level_s[i] & ~level_r[i];
         fall_s[i] = ~level_s[i] & level_r[i];

         if (fall_s[i]) begin
            release_s[i] = 1'b1;
            held_s[i]    = 1'b0;
            timer_s[i]   = '0;
            state_s[i]   = IDLE;
         end else begin
            case (state_r[i])
               IDLE: begin
                  if (rise_s[i]) begin
                     press_s[i] = 1'b1;
                     timer_s[i] = '0;
                     state_s[i] = PRESSED;
                  end else begin
                     timer_s[i] = '0;
                  end
               end
               PRESSED: begin
                  if (timer_r[i] == HOLD_LAST) begin
                     held_s[i]  = 1'b1;
                     press_s[i] = REP_ON;
                     timer_s[i] = '0;
                     state_s[i] = REPEAT;
                  end else begin
                     timer_s[i] = timer_r[i] + TW'(1);
                  end
               end
               REPEAT: begin
                  // Without auto-repeat the timer simply stays frozen here.
                  if (!REP_ON) begin
                     timer_s[i] = timer_r[i];
                  end else if (timer_r[i] == REP_LAST) begin
                     press_s[i] = 1'b1;
                     timer_s[i] = '0;
                  end else begin
                     timer_s[i] = timer_r[i] + TW'(1);
                  end
               end
               default: begin
                  held_s[i]  = 1'b0;
                  timer_s[i] = '0;
                  state_s[i] = IDLE;
               end
            endcase
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r     <= '0;
         sync2_r     <= '0;
         level_r     <= '0;
         press_r     <= '0;
         release_r   <= '0;
         held_r      <= '0;
         any_press_r <= 1'b0;
         for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_r[i] <= '0;
            timer_r[i]  <= '0;
            state_r[i]  <= IDLE;
         end
      end else begin
         sync1_r     <= bus.btn_in;
         sync2_r     <= sync1_r;
         level_r     <= level_s;
         press_r     <= press_s;
         release_r   <= release_s;
         held_r      <= held_s;
         any_press_r <= |press_s;
         db_cnt_r    <= db_cnt_s;
         timer_r     <= timer_s;
         state_r     <= state_s;
      end
   end

   assign bus.btn_level   = level_r;
   assign bus.btn_press   = press_r;
   assign bus.btn_release = release_r;
   assign bus.btn_held    = held_r;
   assign bus.any_press   = any_press_r;
endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: two conditioners (auto-repeat on / off) share one stimulus stream;
// a rule-level model queues expected output events, a monitor pops and compares them.
module tb_button_conditioner;
   localparam int NB = 5;
   localparam int D  = 4;
   localparam int H  = 20;
   localparam int R  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn;

   always #5 clk = ~clk;

   button_conditioner_if #(.NUM_BTN(NB)) bus0 ();
   button_conditioner_if #(.NUM_BTN(NB)) bus1 ();
   assign bus0.btn_in = btn;
   assign bus1.btn_in = btn;

   button_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
                        .REPEAT_CYCLES(R), .REPEAT_EN(1)) dut_rep (
      .clk(clk), .rst(rst), .bus(bus0));
   button_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
                        .REPEAT_CYCLES(R), .REPEAT_EN(0)) dut_norep (
      .clk(clk), .rst(rst), .bus(bus1));

   typedef struct {
      int            cyc;
      logic [NB-1:0] press;
      logic [NB-1:0] rel;
      logic [NB-1:0] lvl;
      logic [NB-1:0] held;
      logic          any;
   } ev_t;

   ev_t exp_q [2][$];

   logic [NB-1:0] o_press [2];
   logic [NB-1:0] o_rel   [2];
   logic [NB-1:0] o_lvl   [2];
   logic [NB-1:0] o_held  [2];
   logic          o_any   [2];
   assign o_press[0] = bus0.btn_press;   assign o_press[1] = bus1.btn_press;
   assign o_rel[0]   = bus0.btn_release; assign o_rel[1]   = bus1.btn_release;
   assign o_lvl[0]   = bus0.btn_level;   assign o_lvl[1]   = bus1.btn_level;
   assign o_held[0]  = bus0.btn_held;    assign o_held[1]  = bus1.btn_held;
   assign o_any[0]   = bus0.any_press;   assign o_any[1]   = bus1.any_press;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   int press_cnt [2][NB];
   int rel_cnt   [2][NB];
   int lvl_cnt   [2][NB];
   int held_cnt  [2][NB];
   int any_cnt   [2];

   // Reference model: level flips after D consecutive differing synced samples;
   // presses occur at the rise and at hold durations H, H+R, H+2R, ...
   initial begin : model
      logic [NB-1:0] s1 [2];
      logic [NB-1:0] s2 [2];
      logic [NB-1:0] lvl [2];
      logic [NB-1:0] held [2];
      int            run [2][NB];
      int            dur [2][NB];
      logic [NB-1:0] old_lvl, old_held;
      ev_t           e;
      for (int d = 0; d < 2; d++) begin
         s1[d] = '0; s2[d] = '0; lvl[d] = '0; held[d] = '0;
         for (int c = 0; c < NB; c++) begin run[d][c] = 0; dur[d][c] = 0; end
      end
      forever begin
         @(posedge clk);
         cyc++;
         for (int d = 0; d < 2; d++) begin
            old_lvl  = lvl[d];
            old_held = held[d];
            e.press  = '0;
            e.rel    = '0;
            if (rst) begin
               s1[d] = '0; s2[d] = '0; lvl[d] = '0; held[d] = '0;
               for (int c = 0; c < NB; c++) begin run[d][c] = 0; dur[d][c] = 0; end
            end else begin
               for (int c = 0; c < NB; c++) begin
                  if (s2[d][c] != lvl[d][c]) begin
                     run[d][c]++;
                     if (run[d][c] == D) begin
                        lvl[d][c] = s2[d][c];
                        run[d][c] = 0;
                     end
                  end else begin
                     run[d][c] = 0;
                  end
                  if (lvl[d][c] && !old_lvl[c]) begin
                     e.press[c] = 1'b1;
                     dur[d][c]  = 0;
                  end else if (!lvl[d][c] && old_lvl[c]) begin
                     e.rel[c]   = 1'b1;
                     held[d][c] = 1'b0;
                  end else if (lvl[d][c]) begin
                     dur[d][c]++;
                     if (dur[d][c] >= H) held[d][c] = 1'b1;
                     if (d == 0 && dur[d][c] >= H && ((dur[d][c] - H) % R) == 0)
                        e.press[c] = 1'b1;
                  end
               end
               s2[d] = s1[d];
               s1[d] = btn;
            end
            e.cyc  = cyc;
            e.lvl  = lvl[d];
            e.held = held[d];
            e.any  = |e.press;
            if (e.press != '0 || e.rel != '0 || lvl[d] != old_lvl || held[d] != old_held)
               exp_q[d].push_back(e);
         end
      end
   end

   // Monitor: whenever a DUT shows a pulse or a level/held change, pop and compare.
   initial begin : monitor
      logic [NB-1:0] p_lvl [2];
      logic [NB-1:0] p_held [2];
      ev_t           e;
      bit            present;
      p_lvl[0] = '0; p_lvl[1] = '0; p_held[0] = '0; p_held[1] = '0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (mon_en) begin
               present = (o_press[d] != '0) || (o_rel[d] != '0) || o_any[d] ||
                         (o_lvl[d] != p_lvl[d]) || (o_held[d] != p_held[d]);
               while (exp_q[d].size() > 0 && exp_q[d][0].cyc < cyc) begin
                  e = exp_q[d].pop_front();
                  checks++; errors++;
                  $display("FAIL missed_event dut%0d cyc %0d: nothing presented, expected press=%b rel=%b lvl=%b held=%b any=%b",
                           d, e.cyc, e.press, e.rel, e.lvl, e.held, e.any);
               end
               if (present) begin
                  checks++;
                  if (exp_q[d].size() > 0 && exp_q[d][0].cyc == cyc) begin
                     e = exp_q[d].pop_front();
                     if (o_press[d] !== e.press || o_rel[d] !== e.rel || o_lvl[d] !== e.lvl ||
                         o_held[d] !== e.held || o_any[d] !== e.any) begin
                        errors++;
                        $display("FAIL outputs dut%0d cyc %0d: got press=%b rel=%b lvl=%b held=%b any=%b, expected press=%b rel=%b lvl=%b held=%b any=%b",
                                 d, cyc, o_press[d], o_rel[d], o_lvl[d], o_held[d], o_any[d],
                                 e.press, e.rel, e.lvl, e.held, e.any);
                     end
                  end else begin
                     errors++;
                     $display("FAIL spurious_event dut%0d cyc %0d: got press=%b rel=%b lvl=%b held=%b any=%b, expected no change",
                              d, cyc, o_press[d], o_rel[d], o_lvl[d], o_held[d], o_any[d]);
                  end
               end
               for (int c = 0; c < NB; c++) begin
                  press_cnt[d][c] += int'(o_press[d][c]);
                  rel_cnt[d][c]   += int'(o_rel[d][c]);
                  lvl_cnt[d][c]   += int'(o_lvl[d][c]);
                  held_cnt[d][c]  += int'(o_held[d][c]);
               end
               any_cnt[d] += int'(o_any[d]);
            end
            p_lvl[d]  = o_lvl[d];
            p_held[d] = o_held[d];
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_counts();
      for (int d = 0; d < 2; d++) begin
         any_cnt[d] = 0;
         for (int c = 0; c < NB; c++) begin
            press_cnt[d][c] = 0; rel_cnt[d][c] = 0; lvl_cnt[d][c] = 0; held_cnt[d][c] = 0;
         end
      end
   endtask

   task automatic check_eq(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   initial begin : stimulus
      btn = '0;
      rst = 1'b1;
      idle(3);
      check_eq("reset_outputs_rep", int'({o_press[0], o_rel[0], o_lvl[0], o_held[0], o_any[0]}), 0);
      check_eq("reset_outputs_norep", int'({o_press[1], o_rel[1], o_lvl[1], o_held[1], o_any[1]}), 0);
      rst    = 1'b0;
      mon_en = 1'b1;
      clear_counts();

      // Clean 12-cycle press on channel 0.
      btn[0] = 1'b1; idle(12); btn[0] = 1'b0; idle(20);
      check_eq("t1_press_cnt", press_cnt[0][0], 1);
      check_eq("t1_release_cnt", rel_cnt[0][0], 1);
      check_eq("t1_level_cycles", lvl_cnt[0][0], 12);
      check_eq("t1_any_cnt", any_cnt[0], 1);

      // Bounce shorter than the debounce window on channel 1.
      clear_counts();
      repeat (3) begin btn[1] = 1'b1; idle(1); btn[1] = 1'b0; idle(1); end
      btn[1] = 1'b1; idle(3); btn[1] = 1'b0; idle(15);
      check_eq("t2_press_cnt", press_cnt[0][1], 0);
      check_eq("t2_level_cycles", lvl_cnt[0][1], 0);
      check_eq("t2_release_cnt", rel_cnt[0][1], 0);

      // Long hold on channel 2: repeat vs. no-repeat instance.
      clear_counts();
      btn[2] = 1'b1; idle(60); btn[2] = 1'b0; idle(20);
      check_eq("t3_rep_press_cnt", press_cnt[0][2], 6);
      check_eq("t3_rep_release_cnt", rel_cnt[0][2], 1);
      check_eq("t3_rep_held_cycles", held_cnt[0][2], 40);
      check_eq("t6_norep_press_cnt", press_cnt[1][2], 1);
      check_eq("t6_norep_release_cnt", rel_cnt[1][2], 1);
      check_eq("t6_norep_held_cycles", held_cnt[1][2], 40);

      // Simultaneous rise on channels 0 and 3.
      clear_counts();
      btn[0] = 1'b1; btn[3] = 1'b1; idle(8); btn = '0; idle(20);
      check_eq("t4_press0_cnt", press_cnt[0][0], 1);
      check_eq("t4_press3_cnt", press_cnt[0][3], 1);
      check_eq("t4_any_cnt", any_cnt[0], 1);

      // Reset while channel 4 is held: no release from the reset itself.
      clear_counts();
      btn[4] = 1'b1; idle(31);
      rst = 1'b1; idle(2); rst = 1'b0;
      idle(50); btn[4] = 1'b0; idle(20);
      check_eq("t5_rep_release_cnt", rel_cnt[0][4], 1);
      check_eq("t5_norep_release_cnt", rel_cnt[1][4], 1);

      // Randomised toggling with occasional resets.
      for (int n = 0; n < 2000; n++) begin
         for (int c = 0; c < NB; c++)
            if ($urandom_range(0, 3 + 5 * c) == 0) btn[c] = ~btn[c];
         rst = ($urandom_range(0, 299) == 0);
         idle(1);
      end
      rst = 1'b0;
      btn = '0;
      idle(40);
      check_eq("drain_rep_queue", exp_q[0].size(), 0);
      check_eq("drain_norep_queue", exp_q[1].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
